// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, direct-mapped I-cache lookup and a
// single-outstanding refill handshake toward instruction memory.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          INDEX_BITS = 4,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc,
  output logic [31:0] next_pc,
  output logic [31:0] instruction,
  output logic        hit
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 32 - INDEX_BITS - 2;

  typedef enum logic [0:0] {LOOKUP, MISS} state_e;

  state_e                  state_q, state_d;
  logic [31:0]             pc_q, pc_d;
  logic                    mem_req_q, mem_req_d;
  logic [31:0]             mem_addr_q, mem_addr_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [31:0]             pend_pc_q, pend_pc_d;
  logic [LINES-1:0]        valid_q, valid_d;

  // Tag/data storage is never reset; valid_q alone qualifies it.
  logic [TAG_W-1:0]        tag_arr  [LINES];
  logic [31:0]             data_arr [LINES];

  logic [INDEX_BITS-1:0]   idx, fill_idx;
  logic [TAG_W-1:0]        tag, fill_tag;
  logic [31:0]             redir_tgt;
  logic                    fill_en;

  assign idx       = pc_q[INDEX_BITS+1:2];
  assign tag       = pc_q[31:INDEX_BITS+2];
  assign fill_idx  = mem_addr_q[INDEX_BITS+1:2];
  assign fill_tag  = mem_addr_q[31:INDEX_BITS+2];
  assign redir_tgt = redirect_pc & ~32'h3;

  assign hit         = (state_q == LOOKUP) && valid_q[idx] && (tag_arr[idx] == tag);
  assign instruction = hit ? data_arr[idx] : NOP_WORD;
  assign next_pc     = pc_q + 32'd4;
  assign pc          = pc_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    valid_d      = valid_q;
    fill_en      = 1'b0;
    case (state_q)
      LOOKUP: begin
        if (redirect) begin
          pc_d = redir_tgt;
        end else if (hit) begin
          if (!stall) pc_d = next_pc;
        end else begin
          mem_req_d  = 1'b1;
          mem_addr_d = pc_q;
          state_d    = MISS;
        end
      end
      MISS: begin
        // The request runs to completion; redirects are parked until the fill.
        if (mem_ready) begin
          fill_en           = 1'b1;
          valid_d[fill_idx] = 1'b1;
          mem_req_d         = 1'b0;
          pend_valid_d      = 1'b0;
          state_d           = LOOKUP;
          if (redirect)          pc_d = redir_tgt;
          else if (pend_valid_q) pc_d = pend_pc_q;
        end else if (redirect) begin
          pend_pc_d    = redir_tgt;
          pend_valid_d = 1'b1;
        end
      end
      default: state_d = LOOKUP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LOOKUP;
      pc_q         <= RESET_PC;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= 32'h0;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= 32'h0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      valid_q      <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_arr[fill_idx]  <= fill_tag;
      data_arr[fill_idx] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: an address-level cache model
// predicts each cycle's outputs; a negedge monitor pops and compares them.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam int          NCYC     = 4000;

  logic        clk = 1'b0;
  logic        rst_n, stall, redirect, mem_ready, mem_req, hit;
  logic [31:0] redirect_pc, mem_rdata, mem_addr, pc, next_pc, instruction;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .INDEX_BITS(4), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .pc(pc), .next_pc(next_pc),
    .instruction(instruction), .hit(hit)
  );

  typedef struct {
    logic [31:0] pc, next_pc, instr, mem_addr;
    logic        hit, mem_req;
  } exp_t;
  exp_t exp_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: a 16-entry table of resident word addresses.
  logic [31:0] m_pc, m_req_addr, m_pend_pc;
  bit          m_busy, m_pend;
  bit          lv [16];
  logic [31:0] la [16];
  logic [31:0] ld [16];
  int          wait_cnt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  function automatic int lidx(input logic [31:0] a);
    return int'((a >> 2) & 32'hF);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_busy = 0; m_req_addr = 32'h0; m_pend = 0; m_pend_pc = 32'h0;
    for (int i = 0; i < 16; i++) lv[i] = 0;
  endtask

  function automatic bit model_hit();
    int i;
    i = lidx(m_pc);
    return !m_busy && lv[i] && (la[i] == m_pc);
  endfunction

  // Advance the model across one rising edge using the inputs held at that edge.
  task automatic model_update();
    bit h;
    int j;
    h = model_hit();
    if (!m_busy) begin
      if (redirect)  m_pc = redirect_pc & ~32'h3;
      else if (h)    begin if (!stall) m_pc = m_pc + 32'd4; end
      else begin
        m_busy = 1; m_req_addr = m_pc; wait_cnt = $urandom_range(0, 3);
      end
    end else if (mem_ready) begin
      j = lidx(m_req_addr);
      lv[j] = 1; la[j] = m_req_addr; ld[j] = mem_word(m_req_addr);
      m_busy = 0;
      if (redirect)    m_pc = redirect_pc & ~32'h3;
      else if (m_pend) m_pc = m_pend_pc;
      m_pend = 0;
    end else if (redirect) begin
      m_pend = 1; m_pend_pc = redirect_pc & ~32'h3;
    end
  endtask

  task automatic drive();
    stall    = ($urandom_range(0, 2) == 0);
    redirect = ($urandom_range(0, m_busy ? 3 : 7) == 0);
    case ($urandom_range(0, 5))
      0, 1, 2: redirect_pc = 32'($urandom_range(0, 127));
      3:       redirect_pc = 32'h0000_0103;
      4:       redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      default: redirect_pc = $urandom;
    endcase
    if (m_busy) begin
      if (wait_cnt == 0) begin mem_ready = 1; mem_rdata = mem_word(m_req_addr); end
      else begin wait_cnt--; mem_ready = 0; mem_rdata = $urandom; end
    end else begin
      mem_ready = ($urandom_range(0, 7) == 0);
      mem_rdata = $urandom;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    int   i;
    i = lidx(m_pc);
    e.pc       = m_pc;
    e.next_pc  = m_pc + 32'd4;
    e.hit      = model_hit();
    e.instr    = e.hit ? ld[i] : NOP;
    e.mem_req  = m_busy;
    e.mem_addr = m_req_addr;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    drive();
    push_exp();
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("pc",          pc,                e.pc);
      check("next_pc",     next_pc,           e.next_pc);
      check("hit",         {31'b0, hit},      {31'b0, e.hit});
      check("instruction", instruction,       e.instr);
      check("mem_req",     {31'b0, mem_req},  {31'b0, e.mem_req});
      check("mem_addr",    mem_addr,          e.mem_addr);
    end
  end

  initial begin
    bit did_rst;
    did_rst = 0;
    rst_n = 0; stall = 0; redirect = 0; redirect_pc = 0; mem_ready = 0; mem_rdata = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_pc",      pc,               RESET_PC);
    check("rst_hit",     {31'b0, hit},     32'h0);
    check("rst_mem_req", {31'b0, mem_req}, 32'h0);
    check("rst_instr",   instruction,      NOP);
    #1 rst_n = 1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      step();
      if (!did_rst && cyc > NCYC / 2 && m_busy) begin
        did_rst = 1;
        @(negedge clk);
        #1 rst_n = 0;
        #1;
        check("midmiss_mem_req",  {31'b0, mem_req}, 32'h0);
        check("midmiss_pc",       pc,               RESET_PC);
        check("midmiss_hit",      {31'b0, hit},     32'h0);
        check("midmiss_mem_addr", mem_addr,         32'h0);
        model_reset();
        stall = 0; redirect = 0; mem_ready = 0;
        @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1;
      end
    end

    @(negedge clk); #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    check("midmiss_reset_seen", {31'b0, did_rst},  32'h1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage: the producer side of the IF/ID pipeline register.
- Holds the PC and looks it up in a small direct-mapped instruction cache.
- Refills the cache from instruction memory through a req/ready handshake on a miss.
- Drives next_pc / instruction / hit, which IF/ID samples on the falling edge of clk; all state in this block updates on the rising edge.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- INDEX_BITS, 4, log2 of cache lines (16 one-word lines).
- NOP_WORD, 32'h0000_0000, instruction driven when hit=0.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  hazard unit: hold PC (ignored while miss outstanding).
- redirect  in  1  branch/jump taken; load redirect_pc.
- redirect_pc  in  32  redirect target; bits [1:0] forced to 0.
- mem_req  out  1  instruction-memory read request (registered).
- mem_addr  out  32  word-aligned read address (registered).
- mem_ready  in  1  memory returns mem_rdata this cycle.
- mem_rdata  in  32  read data, valid when mem_ready=1.
- pc  out  32  current fetch PC (debug/exception use).
- next_pc  out  32  pc+4, to IF/ID.
- instruction  out  32  fetched word, to IF/ID.
- hit  out  1  instruction valid this cycle, to IF/ID.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC; all valid bits=0; state=LOOKUP; mem_req=0; mem_addr=0; pend_valid=0. Tag/data arrays are not reset.
- Address split: index=pc[INDEX_BITS+1:2]; tag=pc[31:INDEX_BITS+2].
- Outputs (combinational from registered state):
  - hit = (state==LOOKUP) & valid[index] & (tag_arr[index]==tag).
  - instruction = hit ? data_arr[index] : NOP_WORD.
  - next_pc = pc+4 modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- State LOOKUP, at posedge, priority order:
  1. redirect=1: pc<=redirect_pc&~3; stay LOOKUP. Wins over stall and miss; no request is issued.
  2. hit & stall: hold pc.
  3. hit & !stall: pc<=pc+4.
  4. miss: mem_req<=1; mem_addr<=pc; go MISS.
- State MISS:
  - mem_req and mem_addr are held stable until mem_ready is sampled 1. The request is never cancelled.
  - redirect=1 while in MISS: pend_pc<=redirect_pc&~3; pend_valid<=1. A later redirect overwrites the earlier one.
  - On mem_ready=1: write data_arr/tag_arr/valid for mem_addr's index; mem_req<=0; go LOOKUP.
    - If pend_valid or redirect is active this cycle: pc<=pending target, with the same-cycle redirect having priority; clear pend_valid.
    - Otherwise pc is unchanged, so the next cycle hits.
  - stall is ignored in MISS; hit=0 throughout.
- Miss penalty: the miss cycle, plus cycles until mem_ready, then a hit on the first LOOKUP cycle. mem_ready in the cycle after the request gives 2 bubble cycles.
- Fills overwrite the resident line unconditionally; there is no write-back.
- mem_ready while mem_req=0 is ignored.
- Reset asserted mid-miss: mem_req drops immediately; the abandoned request is the memory side's responsibility.
- Only one outstanding request at a time.

Test Plan:
- Cold start: release rst_n; mem_ready 3 cycles after mem_req.
  - Expect: mem_req=1 with mem_addr=0x0; hit=0 and instruction=0 until the fill.
  - After the fill: hit=1, instruction=mem word, next_pc=0x4; pc advances to 0x4 next posedge.
- Sequential hits: pre-fill 0x0..0xC, stall=0 → hit=1 for four consecutive cycles; next_pc=0x4,0x8,0xC,0x10.
- Stall: hit at pc=0x8 with stall=1 for 2 cycles → pc stays 0x8, hit=1 both cycles; advances to 0xC after stall drops.
- Redirect during miss: miss at 0x40; redirect to 0x103 one cycle later; mem_ready 2 cycles after that.
  - Expect: line for 0x40 filled; pc=0x100; new miss issued with mem_addr=0x100.
- Conflict eviction (INDEX_BITS=4): fill 0x0, then fetch 0x40 (same index) → miss/refill; refetch 0x0 → miss again.
- Wrap and reset: pc=0xFFFF_FFFC hit → next_pc=0; reset pulse during MISS → mem_req=0 immediately, pc=RESET_PC, hit=0.
